// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer.
package truth_table_sequencer_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One vector for each combination of the four inputs
    localparam int NUM_VEC = 16;

endpackage : truth_table_sequencer_pkg

// File: rtl/truth_table_sequencer_vector_counter.sv
// Hold/index counter: keeps each vector on the bus for HOLD cycles, then
// pulses sample_tick on the last hold cycle and advances the vector index.
module vector_counter
    import truth_table_sequencer_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] index,
    output logic       sample_tick,
    output logic       last_tick
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
    localparam logic [3:0] LAST_VEC  = 4'(NUM_VEC - 1);

    logic [7:0] hold_cnt;

    assign sample_tick = enable && (hold_cnt == HOLD_LAST);
    assign last_tick   = sample_tick && (index == LAST_VEC);

    // Count hold cycles; on the sampling cycle wrap the hold count and step
    // the index, except after the final vector where the index is left alone
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hold_cnt <= 8'd0;
            index    <= 4'd0;
        end else if (enable) begin
            if (sample_tick) begin
                hold_cnt <= 8'd0;
                if (!last_tick) begin
                    index <= index + 4'd1;
                end
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

endmodule : vector_counter

// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sequencer: steps a 4-input unit through all 16
// input vectors, captures its response and compares it to a golden table.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  err_cnt,
    output logic [3:0]  first_bad
);

    localparam logic [4:0] ERR_MAX = 5'(NUM_VEC);

    state_t     state;
    state_t     next_state;
    logic       start_accept;
    logic [3:0] index;
    logic       sample_tick;
    logic       last_tick;

    // A start is only honoured outside a running sweep
    assign start_accept = start && (state != DRIVE);

    vector_counter #(
        .HOLD (HOLD)
    ) u_vector_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_accept),
        .enable      (state == DRIVE),
        .index       (index),
        .sample_tick (sample_tick),
        .last_tick   (last_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a sweep ends on the sampling edge of the last vector
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = DRIVE;
            DRIVE:   if (last_tick) next_state = DONE;
            DONE:    if (start) next_state = DRIVE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the response and track mismatches on every sampling edge
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            captured  <= 16'd0;
            err_cnt   <= 5'd0;
            first_bad <= 4'd0;
        end else if (sample_tick) begin
            captured[index] <= f;
            if (f != expected[index]) begin
                if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + 5'd1;
                end
                if (err_cnt == 5'd0) begin
                    first_bad <= index;
                end
            end
        end
    end

    assign busy         = (state == DRIVE);
    assign done         = (state == DONE);
    assign {A, B, C, D} = busy ? index : 4'b0000;
    assign pass         = done && (captured == expected);

endmodule : truth_table_sequencer

// File: tb/tb_truth_table_sequencer.sv
// Directed self-checking bench for truth_table_sequencer with a 4-input unit
// under test modelled as f = A & B (or tied high).
module tb_truth_table_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] expected;
    logic        f;
    logic        f_tied;
    logic        A, B, C, D;
    logic        busy, done, pass;
    logic [15:0] captured;
    logic [4:0]  err_cnt;
    logic [3:0]  first_bad;

    int vectors;
    int miscompares;

    truth_table_sequencer #(
        .HOLD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .expected  (expected),
        .f         (f),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .captured  (captured),
        .err_cnt   (err_cnt),
        .first_bad (first_bad)
    );

    // Unit under test: a two-input AND on A and B, or a constant 1
    assign f = f_tied ? 1'b1 : (A & B);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] wanted);
        vectors++;
        if (observed !== wanted) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, wanted, $time);
        end
    endtask

    // Pulse start, follow the sweep cycle by cycle, then check the results.
    // glitch_at >= 0 re-pulses start at that cycle of the sweep.
    task automatic applyStimulus(input logic [15:0] exp_tbl, input logic [15:0] want_cap,
                                 input int want_err, input int want_fb, input logic want_pass,
                                 input int glitch_at);
        @(negedge clk);
        expected = exp_tbl;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            checkOutput("vector", {28'd0, A, B, C, D}, 32'(k / 4));
            checkOutput("busy", {31'd0, busy}, 32'd1);
            checkOutput("done_low", {31'd0, done}, 32'd0);
            start = (k == glitch_at);
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("done", {31'd0, done}, 32'd1);
        checkOutput("busy_end", {31'd0, busy}, 32'd0);
        checkOutput("abcd_end", {28'd0, A, B, C, D}, 32'd0);
        checkOutput("captured", {16'd0, captured}, {16'd0, want_cap});
        checkOutput("err_cnt", {27'd0, err_cnt}, 32'(want_err));
        checkOutput("first_bad", {28'd0, first_bad}, 32'(want_fb));
        checkOutput("pass", {31'd0, pass}, {31'd0, want_pass});
    endtask

    // Check that every output is back at its reset value
    task automatic checkIdle(input string tag);
        checkOutput({tag, "_abcd"}, {28'd0, A, B, C, D}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_pass"}, {31'd0, pass}, 32'd0);
        checkOutput({tag, "_captured"}, {16'd0, captured}, 32'd0);
        checkOutput({tag, "_err_cnt"}, {27'd0, err_cnt}, 32'd0);
        checkOutput({tag, "_first_bad"}, {28'd0, first_bad}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        expected    = 16'hF000;
        f_tied      = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;

        $display("[TB] sweep: f = A&B, golden F000");
        applyStimulus(16'hF000, 16'hF000, 0, 0, 1'b1, -1);

        $display("[TB] sweep: golden F001, one mismatch at vector 0");
        applyStimulus(16'hF001, 16'hF000, 1, 0, 1'b0, -1);

        $display("[TB] sweep: golden 7000, one mismatch at vector 15");
        applyStimulus(16'h7000, 16'hF000, 1, 15, 1'b0, -1);

        $display("[TB] sweep: start re-pulsed at cycle 20");
        applyStimulus(16'hF000, 16'hF000, 0, 0, 1'b1, 20);

        $display("[TB] sweep: f tied high, golden 0000");
        f_tied = 1'b1;
        applyStimulus(16'h0000, 16'hFFFF, 16, 0, 1'b0, -1);

        $display("[TB] sweep aborted by reset at cycle 30");
        @(negedge clk);
        expected = 16'h0000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd1);
        checkOutput("abort_err_nonzero", {31'd0, (err_cnt != 5'd0)}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkIdle("abort");
        rst    = 1'b0;
        f_tied = 1'b0;

        $display("[TB] sweep after abort");
        applyStimulus(16'hF000, 16'hF000, 0, 0, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_truth_table_sequencer
